aes_block_loader: RTL and testbench

- Upstream feeder for the AES encrypt/decrypt top level. Assembles a byte stream (e.g. from a UART receiver) into the 128-bit key and 128-bit plaintext words the AES datapath consumes.
- Presents both words as stable registered buses, plus one-cycle strobes that tell the AES stage when new data is valid.
- Frames are command-prefixed. A per-frame inactivity timeout aborts partially received frames.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_byte_shifter.sv | 37 +++
 rtl/aes_block_loader.sv | 143 ++++++++++++++
 tb/tb_aes_block_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared widths, FSM states, error codes and default command bytes for the AES block loader.
// Pure declarations: no latency, no backpressure.
package aes_pkg;

    localparam int AES_BLK_W     = 128;
    localparam int AES_BLK_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RX_KEY  = 2'd1,
        RX_TEXT = 2'd2,
        COMMIT  = 2'd3
    } loaderState_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_BADCMD  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_NOKEY   = 2'b11;

    localparam logic [7:0] DEF_CMD_KEY  = 8'h4B;
    localparam logic [7:0] DEF_CMD_TEXT = 8'h50;

endpackage

// File: rtl/aes_byte_shifter.sv
// 16-byte big-endian assembly register with byte counter; one byte per shiftEn, clr wins.
// Latency: data visible the cycle after the shift; no backpressure of its own.
module aes_byte_shifter
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 shiftEn,
    input  logic [7:0]           din,
    output logic [AES_BLK_W-1:0] data,
    output logic                 lastSlot,
    output logic                 full
);
    localparam int              CW       = $clog2(AES_BLK_BYTES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(AES_BLK_BYTES - 1);

    logic [CW-1:0] byteCnt;

    // New bytes enter at the LSB end so the first byte lands in the top lane.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            data    <= '0;
            byteCnt <= '0;
            full    <= 1'b0;
        end else if (shiftEn) begin
            data    <= {data[AES_BLK_W-9:0], din};
            byteCnt <= byteCnt + 1'b1;
            if (byteCnt == CNT_LAST) begin
                full <= 1'b1;
            end
        end
    end

    assign lastSlot = (byteCnt == CNT_LAST);

endmodule

// File: rtl/aes_block_loader.sv
// Command-framed byte stream to held 128-bit key/plaintext buses; strobe two cycles after the 16th byte.
// oReady drops for the single COMMIT cycle only; partial frames abort after TIMEOUT idle cycles.
module aes_block_loader
    import aes_pkg::*;
#(
    parameter int         TIMEOUT  = 1000,
    parameter logic [7:0] CMD_KEY  = DEF_CMD_KEY,
    parameter logic [7:0] CMD_TEXT = DEF_CMD_TEXT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           iData,
    input  logic                 iValid,
    output logic                 oReady,
    output logic [AES_BLK_W-1:0] oKey,
    output logic [AES_BLK_W-1:0] oPlaintext,
    output logic                 oKeyValid,
    output logic                 oStart,
    output logic                 oErr,
    output logic [1:0]           oErrCode
);
    localparam int            TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    loaderState_t            state, stateNext;
    logic [TW-1:0]           tmoCnt;
    logic                    keyLoaded;
    logic                    frameIsKey;
    logic                    accept;
    logic                    inRx;
    logic                    shClr;
    logic                    badCmd;
    logic                    tmoHit;
    logic [AES_BLK_W-1:0]    shData;
    logic                    shLast;
    logic                    shFull;

    assign accept = iValid && oReady;
    assign inRx   = (state == RX_KEY) || (state == RX_TEXT);

    always_comb begin
        stateNext = state;
        shClr     = 1'b0;
        badCmd    = 1'b0;
        tmoHit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (iData == CMD_KEY) begin
                        stateNext = RX_KEY;
                        shClr     = 1'b1;
                    end else if (iData == CMD_TEXT) begin
                        stateNext = RX_TEXT;
                        shClr     = 1'b1;
                    end else begin
                        badCmd = 1'b1;
                    end
                end
            end
            RX_KEY, RX_TEXT: begin
                // An accepted byte always beats an expiring idle count.
                if (accept) begin
                    if (shLast) begin
                        stateNext = COMMIT;
                    end
                end else if (tmoCnt == TMO_LAST) begin
                    stateNext = IDLE;
                    shClr     = 1'b1;
                    tmoHit    = 1'b1;
                end
            end
            COMMIT:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    aes_byte_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .clr      (shClr),
        .shiftEn  (accept && inRx),
        .din      (iData),
        .data     (shData),
        .lastSlot (shLast),
        .full     (shFull)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            oReady     <= 1'b1;
            tmoCnt     <= '0;
            keyLoaded  <= 1'b0;
            frameIsKey <= 1'b0;
            oKey       <= '0;
            oPlaintext <= '0;
            oKeyValid  <= 1'b0;
            oStart     <= 1'b0;
            oErr       <= 1'b0;
            oErrCode   <= ERR_NONE;
        end else begin
            state     <= stateNext;
            oReady    <= (stateNext != COMMIT);
            oKeyValid <= 1'b0;
            oStart    <= 1'b0;
            oErr      <= 1'b0;

            if (inRx && (stateNext == state)) begin
                tmoCnt <= accept ? '0 : tmoCnt + 1'b1;
            end else begin
                tmoCnt <= '0;
            end

            if (state == IDLE && shClr) begin
                frameIsKey <= (stateNext == RX_KEY);
            end

            if (badCmd) begin
                oErr     <= 1'b1;
                oErrCode <= ERR_BADCMD;
            end
            if (tmoHit) begin
                oErr     <= 1'b1;
                oErrCode <= ERR_TIMEOUT;
            end

            if (state == COMMIT && shFull) begin
                if (frameIsKey) begin
                    oKey      <= shData;
                    keyLoaded <= 1'b1;
                    oKeyValid <= 1'b1;
                end else if (keyLoaded) begin
                    oPlaintext <= shData;
                    oStart     <= 1'b1;
                end else begin
                    oErr     <= 1'b1;
                    oErrCode <= ERR_NOKEY;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader with TIMEOUT=8 and hand-computed expected buses and strobes.
module tb_aes_block_loader;
    import aes_pkg::*;

    logic         clk    = 1'b0;
    logic         rst    = 1'b1;
    logic [7:0]   iData  = 8'h00;
    logic         iValid = 1'b0;
    logic         oReady;
    logic [127:0] oKey;
    logic [127:0] oPlaintext;
    logic         oKeyValid;
    logic         oStart;
    logic         oErr;
    logic [1:0]   oErrCode;

    int nChecks = 0;
    int nErrors = 0;
    int keyVldCnt = 0;
    int startCnt = 0;
    int errCnt = 0;
    int readyLowCnt = 0;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] PT1  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] FILL = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;
    localparam logic [127:0] KEY2 = 128'h101112131415161718191A1B1C1D1E1F;
    localparam logic [127:0] KEY3 = 128'h202122232425262728292A2B2C2D2E2F;
    localparam logic [127:0] KEY4 = 128'h303132333435363738393A3B3C3D3E3F;
    localparam logic [127:0] KEY5 = 128'h404142434445464748494A4B4C4D4E4F;
    localparam logic [127:0] KEY6 = 128'h505152535455565758595A5B5C5D5E5F;

    aes_block_loader #(
        .TIMEOUT  (8),
        .CMD_KEY  (8'h4B),
        .CMD_TEXT (8'h50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iData      (iData),
        .iValid     (iValid),
        .oReady     (oReady),
        .oKey       (oKey),
        .oPlaintext (oPlaintext),
        .oKeyValid  (oKeyValid),
        .oStart     (oStart),
        .oErr       (oErr),
        .oErrCode   (oErrCode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (oKeyValid) keyVldCnt++;
            if (oStart) startCnt++;
            if (oErr) errCnt++;
            if (!oReady) readyLowCnt++;
            if (oKeyValid || oStart || oErr)
                check("strobe_onehot", 128'(int'(oKeyValid) + int'(oStart) + int'(oErr)), 128'd1);
        end
    end

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; iValid = 1'b0; iData = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        keyVldCnt = 0; startCnt = 0; errCnt = 0; readyLowCnt = 0;
    endtask

    // Presents a byte from a negedge and returns just after the edge that accepts it.
    task automatic sendByte(input logic [7:0] b);
        logic accepted;
        @(negedge clk);
        iData = b; iValid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 4 && !accepted; i++) begin
            if (i > 0) @(negedge clk);
            accepted = oReady;
            @(posedge clk);
        end
        if (!accepted) check("accept_bound", 128'(accepted), 128'd1);
    endtask

    task automatic sendFrame(input logic [7:0] cmd, input logic [127:0] payload);
        sendByte(cmd);
        for (int i = 0; i < 16; i++) sendByte(payload[127-8*i -: 8]);
    endtask

    task automatic finishFrame();
        @(negedge clk);
        iValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        doReset();
        check("rst_key",     oKey,               128'd0);
        check("rst_pt",      oPlaintext,         128'd0);
        check("rst_ready",   128'(oReady),       128'd1);
        check("rst_strobes", 128'({oKeyValid, oStart, oErr}), 128'd0);
        check("rst_errcode", 128'(oErrCode),     128'd0);

        // Key then text, with exact strobe latency.
        sendFrame(8'h4B, KEY1);
        finishFrame();
        check("kt_commit_ready", 128'(oReady),    128'd0);
        check("kt_kv_early",     128'(oKeyValid), 128'd0);
        @(negedge clk);
        check("kt_kv",   128'(oKeyValid), 128'd1);
        check("kt_key",  oKey,            KEY1);
        sendFrame(8'h50, PT1);
        finishFrame();
        check("kt_start_early", 128'(oStart), 128'd0);
        @(negedge clk);
        check("kt_start", 128'(oStart), 128'd1);
        check("kt_pt",    oPlaintext,   PT1);
        @(negedge clk);
        check("kt_start_pulse", 128'(oStart), 128'd0);
        check("kt_pt_hold",     oPlaintext,   PT1);
        check("kt_key_hold",    oKey,         KEY1);
        #1;
        check("kt_kv_count",    128'(keyVldCnt), 128'd1);
        check("kt_start_count", 128'(startCnt),  128'd1);
        check("kt_err_count",   128'(errCnt),    128'd0);

        // Text frame with no key loaded.
        doReset();
        sendFrame(8'h50, FILL);
        finishFrame();
        @(negedge clk);
        check("nk_err",     128'(oErr),     128'd1);
        check("nk_errcode", 128'(oErrCode), 128'(ERR_NOKEY));
        @(negedge clk);
        check("nk_err_pulse", 128'(oErr),     128'd0);
        check("nk_code_hold", 128'(oErrCode), 128'(ERR_NOKEY));
        check("nk_pt",        oPlaintext,     128'd0);
        #1;
        check("nk_start_count", 128'(startCnt), 128'd0);

        // Bad command, then a normal key frame.
        sendByte(8'h7E);
        finishFrame();
        check("bc_err",     128'(oErr),     128'd1);
        check("bc_errcode", 128'(oErrCode), 128'(ERR_BADCMD));
        check("bc_ready",   128'(oReady),   128'd1);
        sendFrame(8'h4B, KEY2);
        finishFrame();
        @(negedge clk);
        check("bc_kv",  128'(oKeyValid), 128'd1);
        check("bc_key", oKey,            KEY2);

        // Timeout: 5 data bytes then idle; abort after 8 idle edges.
        sendByte(8'h4B);
        for (int i = 0; i < 5; i++) sendByte(8'hEE);
        finishFrame();
        repeat (7) @(negedge clk);
        check("to_not_yet", 128'(oErr), 128'd0);
        @(negedge clk);
        check("to_err",     128'(oErr),     128'd1);
        check("to_errcode", 128'(oErrCode), 128'(ERR_TIMEOUT));
        check("to_key",     oKey,           KEY2);
        sendFrame(8'h4B, KEY3);
        finishFrame();
        @(negedge clk);
        check("to_fresh_key", oKey, KEY3);

        // A byte arriving on the expiring cycle cancels the timeout.
        errCnt = 0;
        sendByte(8'h4B);
        sendByte(8'h30);
        finishFrame();
        repeat (6) @(negedge clk);
        for (int i = 1; i < 16; i++) sendByte(8'(8'h30 + i));
        finishFrame();
        @(negedge clk);
        check("edge_key", oKey, KEY4);
        #1;
        check("edge_err_count", 128'(errCnt), 128'd0);

        // Back-to-back key frames with iValid held high throughout.
        keyVldCnt = 0; readyLowCnt = 0;
        sendFrame(8'h4B, KEY5);
        sendFrame(8'h4B, KEY6);
        finishFrame();
        @(negedge clk);
        check("bp_key", oKey, KEY6);
        @(negedge clk);
        #1;
        check("bp_ready_low", 128'(readyLowCnt), 128'd2);
        check("bp_kv_count",  128'(keyVldCnt),   128'd2);

        // Reset in the middle of a key frame.
        sendByte(8'h4B);
        for (int i = 0; i < 8; i++) sendByte(8'h77);
        @(negedge clk);
        rst = 1'b1; iValid = 1'b0;
        @(negedge clk);
        check("mr_key",     oKey,           128'd0);
        check("mr_pt",      oPlaintext,     128'd0);
        check("mr_ready",   128'(oReady),   128'd1);
        check("mr_errcode", 128'(oErrCode), 128'd0);
        rst = 1'b0;
        sendFrame(8'h50, FILL);
        finishFrame();
        @(negedge clk);
        check("mr_nokey_err",  128'(oErr),     128'd1);
        check("mr_nokey_code", 128'(oErrCode), 128'(ERR_NOKEY));

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
